wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- MEM/WB pipeline register and write-back formatter.
- Captures the memory-stage result, extracts and extends load data, and selects link, ALU or load data as the write value.
- Drives the register file write port (RD, WData, RegWr) and exposes a forwarding copy to the hazard unit.
- Keeps a retired-instruction counter; latency from MEM inputs to write-back outputs is one Clk.

Parameters:
- LINK_OFFSET, 4: byte offset added to MemPC for link writes (JAL/JALR).
- CNT_W, 32: width of the InstRet counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hold the current WB contents.
- Flush  input  1  replace the incoming instruction with a bubble.
- MemValid  input  1  MEM stage holds a real instruction.
- MemRD  input  5  destination register.
- MemRegWr  input  1  instruction writes a register.
- MemLink  input  1  write-back value is MemPC+LINK_OFFSET.
- MemLoadType  input  3  0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU; 6-7 treated as 0.
- MemALUOut  input  32  ALU result; also the load address.
- MemRData  input  32  data-memory read word (big-endian).
- MemPC  input  32  instruction PC.
- RD  output  5  register file write address.
- WData  output  32  register file write data.
- RegWr  output  1  register file write enable.
- WbValid  output  1  WB holds a real instruction.
- WbPC  output  32  PC of the WB instruction.
- FwdValid  output  1  equals RegWr; forwarding is legal.
- AlignErr  output  1  WB instruction is a misaligned load.
- InstRet  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (sync, Reset=1 at posedge): all registered state is 0. RD=0, WData=0, RegWr=0, WbValid=0, WbPC=0, AlignErr=0, InstRet=0. Reset overrides Stall and Flush. Reset asserted mid-stall discards the held instruction.
- Update priority each posedge: Reset > Flush > Stall > capture.
  - Flush: WbValid←0, RegWr←0, AlignErr←0. Other fields are don't-care but keep their previous value.
  - Stall (no Flush): every register holds its value.
  - Capture: WbValid←MemValid. RD, WbPC and the formatted data are latched from the MEM inputs.
- Load extraction, computed combinationally from MemALUOut[1:0] and registered into WData:
  - LW: whole word.
  - LH/LHU: addr[1]=0 selects bits[31:16]; addr[1]=1 selects bits[15:0].
  - LB/LBU: addr 0..3 selects bits [31:24],[23:16],[15:8],[7:0].
  - LH and LB sign-extend; LHU and LBU zero-extend.
- Misalignment:
  - LW with addr[1:0]≠0 is misaligned.
  - LH/LHU with addr[0]=1 is misaligned.
  - A misaligned load captured with MemValid=1 sets AlignErr=1 and forces RegWr=0. WData is still the formatted value.
- WData select: MemLink=1 → MemPC+LINK_OFFSET, modulo 2^32. Otherwise MemLoadType≠0 → formatted load data. Otherwise MemALUOut. MemLink has priority over MemLoadType.
- RegWr is registered as MemValid & MemRegWr & (MemRD≠0) & ~misaligned.
  - Writes to r0 are suppressed here; the register file also ignores r0.
- Outputs are registered and stable for the full cycle in which the register file samples them.
- FwdValid = RegWr. Forwarding consumers compare RD against their source registers.
- InstRet:
  - Increments by 1 on each posedge where WbValid=1, Stall=0 and Reset=0.
  - A stalled WB instruction is counted once, when it leaves.
  - Flushed or misaligned instructions still count if WbValid=1; a misaligned instruction is retired with an exception.
  - Wraps from all-ones to 0.
- Stall and Flush both asserted: Flush wins, and the WB register becomes a bubble.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles, MemValid=1 with random inputs → all outputs 0 while Reset is high. First capture appears one cycle after Reset falls.
- ALU write and r0 suppression: MemRD=5, MemALUOut=0x1234_5678, MemRegWr=1 → next cycle RD=5, WData=0x12345678, RegWr=1. Repeat with MemRD=0 → RegWr=0, WbValid=1.
- Load formatting with MemRData=0x80FF_7F01:
  - LB, addr 0 → WData=0xFFFFFF80.
  - LBU, addr 1 → 0x000000FF.
  - LH, addr 2 → 0x00007F01.
  - LHU, addr 0 → 0x000080FF.
  - LW, addr 0 → 0x80FF7F01.
- Misaligned load: LW at addr 0x1002, MemRegWr=1 → AlignErr=1, RegWr=0, InstRet increments. LH at addr 0x1001 → same response.
- Link write: MemLink=1, MemPC=0x0040_0010, MemLoadType=1 → WData=0x00400014.
- Stall, flush and counter:
  - Stall for 3 cycles with changing MEM inputs → outputs frozen, InstRet unchanged.
  - Stall and Flush together → WbValid=0.
  - Preload InstRet to 0xFFFFFFFF by force, then retire one instruction → InstRet=0.

Source files
------------

// File: rtl/wb_stage_if.sv
// ============================================================================
// Module      : wb_stage_if
// Description : MEM-to-WB bus bundle: memory-stage inputs and write-back
//               outputs of the MEM/WB pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_stage_if #(
    parameter int CNT_W = 32
);
    // MEM-stage side
    logic              MemValid;
    logic [4:0]        MemRD;
    logic              MemRegWr;
    logic              MemLink;
    logic [2:0]        MemLoadType;
    logic [31:0]       MemALUOut;
    logic [31:0]       MemRData;
    logic [31:0]       MemPC;
    // write-back side
    logic [4:0]        RD;
    logic [31:0]       WData;
    logic              RegWr;
    logic              WbValid;
    logic [31:0]       WbPC;
    logic              FwdValid;
    logic              AlignErr;
    logic [CNT_W-1:0]  InstRet;

    modport master (
        output MemValid, MemRD, MemRegWr, MemLink, MemLoadType,
               MemALUOut, MemRData, MemPC,
        input  RD, WData, RegWr, WbValid, WbPC, FwdValid, AlignErr, InstRet
    );

    modport slave (
        input  MemValid, MemRD, MemRegWr, MemLink, MemLoadType,
               MemALUOut, MemRData, MemPC,
        output RD, WData, RegWr, WbValid, WbPC, FwdValid, AlignErr, InstRet
    );
endinterface

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : MEM/WB pipeline register with load extraction, write-value
//               select, register-file write port and retired-instr counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage #(
    parameter int LINK_OFFSET = 4,
    parameter int CNT_W       = 32
) (
    input  wire logic   Clk,
    input  wire logic   Reset,
    input  wire logic   Stall,
    input  wire logic   Flush,
    wb_stage_if.slave   wb
);

    localparam logic [2:0] c_LD_NONE = 3'd0;
    localparam logic [2:0] c_LD_LW   = 3'd1;
    localparam logic [2:0] c_LD_LH   = 3'd2;
    localparam logic [2:0] c_LD_LHU  = 3'd3;
    localparam logic [2:0] c_LD_LB   = 3'd4;
    localparam logic [2:0] c_LD_LBU  = 3'd5;

    logic [1:0]       w_addr;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic             w_is_load;
    logic             w_misalign;
    logic [31:0]      w_wdata;
    logic             w_regwr;
    logic             w_alignerr;

    logic [4:0]       r_rd;
    logic [31:0]      r_wdata;
    logic             r_regwr;
    logic             r_valid;
    logic [31:0]      r_pc;
    logic             r_alignerr;
    logic [CNT_W-1:0] r_instret;

    assign w_addr = wb.MemALUOut[1:0];

    // Memory words are big-endian: the lowest address holds the top byte.
    always_comb begin
        w_byte = 8'd0;
        case (w_addr)
            2'd0:    w_byte = wb.MemRData[31:24];
            2'd1:    w_byte = wb.MemRData[23:16];
            2'd2:    w_byte = wb.MemRData[15:8];
            default: w_byte = wb.MemRData[7:0];
        endcase
    end

    assign w_half = w_addr[1] ? wb.MemRData[15:0] : wb.MemRData[31:16];

    always_comb begin
        w_load     = wb.MemRData;
        w_is_load  = 1'b1;
        w_misalign = 1'b0;
        case (wb.MemLoadType)
            c_LD_LW: begin
                w_load     = wb.MemRData;
                w_misalign = (w_addr != 2'd0);
            end
            c_LD_LH: begin
                w_load     = {{16{w_half[15]}}, w_half};
                w_misalign = w_addr[0];
            end
            c_LD_LHU: begin
                w_load     = {16'd0, w_half};
                w_misalign = w_addr[0];
            end
            c_LD_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU: w_load = {24'd0, w_byte};
            default:  w_is_load = 1'b0;  // none, and reserved codes 6-7
        endcase
    end

    always_comb begin
        w_wdata = wb.MemALUOut;
        if (wb.MemLink) begin
            w_wdata = wb.MemPC + 32'(LINK_OFFSET);
        end else if (w_is_load && (wb.MemLoadType != c_LD_NONE)) begin
            w_wdata = w_load;
        end
    end

    assign w_alignerr = wb.MemValid & w_misalign;
    assign w_regwr    = wb.MemValid & wb.MemRegWr & (wb.MemRD != 5'd0) & ~w_misalign;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd       <= 5'd0;
            r_wdata    <= 32'd0;
            r_regwr    <= 1'b0;
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_alignerr <= 1'b0;
            r_instret  <= '0;
        end else begin
            // The WB occupant retires the moment it leaves, flushed or not.
            if (r_valid && !Stall) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (Flush) begin
                r_valid    <= 1'b0;
                r_regwr    <= 1'b0;
                r_alignerr <= 1'b0;
            end else if (!Stall) begin
                r_rd       <= wb.MemRD;
                r_wdata    <= w_wdata;
                r_regwr    <= w_regwr;
                r_valid    <= wb.MemValid;
                r_pc       <= wb.MemPC;
                r_alignerr <= w_alignerr;
            end
        end
    end

    assign wb.RD       = r_rd;
    assign wb.WData    = r_wdata;
    assign wb.RegWr    = r_regwr;
    assign wb.WbValid  = r_valid;
    assign wb.WbPC     = r_pc;
    assign wb.FwdValid = r_regwr;
    assign wb.AlignErr = r_alignerr;
    assign wb.InstRet  = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module      : tb_wb_stage
// Description : Scoreboard bench for wb_stage with directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        regwr;
        logic        valid;
        logic [31:0] pc;
        logic        alignerr;
        logic [31:0] instret;
    } exp_t;

    typedef struct {
        logic        rst, stall, flush, valid, regwr, link, force_max;
        logic [4:0]  rd;
        logic [2:0]  lt;
        logic [31:0] alu, rdata, pc;
    } stim_t;

    logic clk = 1'b0;
    logic rst, stall, flush;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t m = '0;

    wb_stage_if #(.CNT_W(32)) bus ();

    wb_stage #(.LINK_OFFSET(4), .CNT_W(32)) dut (
        .Clk   (clk),
        .Reset (rst),
        .Stall (stall),
        .Flush (flush),
        .wb    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: load value from the byte address, big-endian word.
    function automatic logic [31:0] fmt(input logic [2:0] lt, input logic [31:0] addr,
                                        input logic [31:0] w);
        int unsigned a = addr % 4;
        logic [31:0] b = (w >> (8 * (3 - a))) & 32'hFF;
        logic [31:0] h = (w >> (16 * (1 - a / 2))) & 32'hFFFF;
        case (lt)
            3'd1:    return w;
            3'd2:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd3:    return h;
            3'd4:    return (b >= 32'h80) ? b - 32'h100 : b;
            default: return b;
        endcase
    endfunction

    function automatic logic misal(input logic [2:0] lt, input logic [31:0] addr);
        if (lt == 3'd1) return (addr % 4) != 0;
        if (lt == 3'd2 || lt == 3'd3) return (addr % 2) != 0;
        return 1'b0;
    endfunction

    task automatic drive(input stim_t s);
        logic inc;
        @(negedge clk);
        rst = s.rst; stall = s.stall; flush = s.flush;
        bus.MemValid = s.valid; bus.MemRD = s.rd; bus.MemRegWr = s.regwr;
        bus.MemLink = s.link; bus.MemLoadType = s.lt; bus.MemALUOut = s.alu;
        bus.MemRData = s.rdata; bus.MemPC = s.pc;
        if (s.force_max) begin
            force dut.r_instret = 32'hFFFF_FFFF;
            #1;
            release dut.r_instret;
            m.instret = 32'hFFFF_FFFF;
        end
        inc = m.valid & ~s.stall;
        if (s.rst) begin
            m = '0;
        end else begin
            if (inc) m.instret = m.instret + 1;
            if (s.flush) begin
                m.valid = 0; m.regwr = 0; m.alignerr = 0;
            end else if (!s.stall) begin
                m.rd       = s.rd;
                m.pc       = s.pc;
                m.valid    = s.valid;
                m.alignerr = s.valid && misal(s.lt, s.alu);
                m.regwr    = s.valid && s.regwr && s.rd != 0 && !misal(s.lt, s.alu);
                if (s.link)                      m.wdata = s.pc + 4;
                else if (s.lt >= 1 && s.lt <= 5) m.wdata = fmt(s.lt, s.alu, s.rdata);
                else                             m.wdata = s.alu;
            end
        end
        q.push_back(m);
        @(posedge clk);
        #2;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.valid = 1'b1; s.regwr = 1'b1; s.rd = 5'd1;
        s.alu = 32'h0000_1000; s.rdata = 32'h80FF_7F01; s.pc = 32'h0000_0100;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s = '{default: '0};
        s.rst   = ($urandom_range(0, 39) == 0);
        s.stall = ($urandom_range(0, 4) == 0);
        s.flush = ($urandom_range(0, 9) == 0);
        s.valid = ($urandom_range(0, 3) != 0);
        s.regwr = ($urandom_range(0, 3) != 0);
        s.link  = ($urandom_range(0, 7) == 0);
        s.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        s.lt    = 3'($urandom);
        s.alu   = $urandom; s.rdata = $urandom; s.pc = $urandom;
        return s;
    endfunction

    // Monitor: one expected snapshot per clock edge after stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("RD",       32'(bus.RD),       32'(e.rd));
                chk("WData",    bus.WData,         e.wdata);
                chk("RegWr",    32'(bus.RegWr),    32'(e.regwr));
                chk("FwdValid", 32'(bus.FwdValid), 32'(e.regwr));
                chk("WbValid",  32'(bus.WbValid),  32'(e.valid));
                chk("WbPC",     bus.WbPC,          e.pc);
                chk("AlignErr", 32'(bus.AlignErr), 32'(e.alignerr));
                chk("InstRet",  bus.InstRet,       e.instret);
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        logic [2:0]  lts [5] = '{3'd4, 3'd5, 3'd2, 3'd3, 3'd1};
        logic [1:0]  ads [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01,
                                 32'h0000_80FF, 32'h80FF_7F01};
        rst = 1'b1; stall = 1'b0; flush = 1'b0;

        for (int i = 0; i < 2; i++) begin
            s = rnd(); s.rst = 1; s.valid = 1;
            drive(s);
            chk("reset WbValid", 32'(bus.WbValid), 32'd0);
            chk("reset InstRet", bus.InstRet, 32'd0);
        end

        s = idle(); s.rd = 5'd5; s.alu = 32'h1234_5678;
        drive(s);
        chk("alu WData", bus.WData, 32'h1234_5678);
        chk("alu RegWr", 32'(bus.RegWr), 32'd1);
        s.rd = 5'd0;
        drive(s);
        chk("r0 RegWr",   32'(bus.RegWr),   32'd0);
        chk("r0 WbValid", 32'(bus.WbValid), 32'd1);

        for (int i = 0; i < 5; i++) begin
            s = idle(); s.lt = lts[i]; s.alu = 32'h0000_1000 | 32'(ads[i]);
            drive(s);
            chk("load WData", bus.WData, exps[i]);
        end

        s = idle(); s.lt = 3'd1; s.alu = 32'h0000_1002;
        drive(s);
        chk("LW misalign AlignErr", 32'(bus.AlignErr), 32'd1);
        chk("LW misalign RegWr",    32'(bus.RegWr),    32'd0);
        s.lt = 3'd2; s.alu = 32'h0000_1001;
        drive(s);
        chk("LH misalign AlignErr", 32'(bus.AlignErr), 32'd1);

        s = idle(); s.link = 1; s.pc = 32'h0040_0010; s.lt = 3'd1;
        drive(s);
        chk("link WData", bus.WData, 32'h0040_0014);

        for (int i = 0; i < 3; i++) begin
            s = rnd(); s.rst = 0; s.flush = 0; s.stall = 1;
            drive(s);
            chk("stall WData", bus.WData, 32'h0040_0014);
        end

        s = idle(); s.stall = 1; s.flush = 1;
        drive(s);
        chk("stall+flush WbValid", 32'(bus.WbValid), 32'd0);

        s = idle();
        drive(s);
        s.force_max = 1;
        drive(s);
        chk("InstRet wrap", bus.InstRet, 32'd0);

        for (int i = 0; i < 400; i++) drive(rnd());

        @(posedge clk);
        #3;
        chk("queue drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
